// File: rtl/adder_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// adder_seq_ctrl_if
//   Request/result bundle between a requesting master and the multi-precision
//   add sequencer.
//   master : drives start, a, b, cin; observes busy, done, sum, cout, ovf
//   slave  : the sequencer side (inverse directions)
//   N = WIDTH*SLICES is the full operand width.
// ----------------------------------------------------------------------------
interface adder_seq_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int SLICES = 4
);
  localparam int N = WIDTH * SLICES;

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/adder_seq_ctrl.sv
// ----------------------------------------------------------------------------
// adder_seq_ctrl
//   Sequences an N-bit (N = WIDTH*SLICES) addition over one shared WIDTH-bit
//   ripple adder slice, LSB slice first, one slice per clock. The carry
//   between slices is held in a register, so there is no lookahead path.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    adder_seq_ctrl_if.slave
//            start/a/b/cin in  : request, captured when the block is idle/done
//            busy             : high while slices are being summed
//            done             : one-cycle pulse, sum/cout/ovf just updated
//            sum/cout/ovf     : last result, held until the next completion
// ----------------------------------------------------------------------------

// Combinational WIDTH-bit adder slice: {cout, s} = a + b + cin.
module adder_slice #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);
  logic [WIDTH:0] total_s;

  assign total_s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign s       = total_s[WIDTH-1:0];
  assign cout    = total_s[WIDTH];
endmodule

module adder_seq_ctrl #(
  parameter int WIDTH  = 8,
  parameter int SLICES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  adder_seq_ctrl_if.slave bus
);
  localparam int IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  // Operands and partial result are kept slice-addressable.
  logic [SLICES-1:0][WIDTH-1:0] a_r;
  logic [SLICES-1:0][WIDTH-1:0] b_r;
  logic [SLICES-1:0][WIDTH-1:0] shadow_r;
  logic [SLICES-1:0][WIDTH-1:0] final_sum_s;
  logic [IDX_W-1:0]             idx_r;
  logic                         carry_r;

  logic [WIDTH-1:0] sl_sum_s;
  logic             sl_cout_s;

  logic             busy_r;
  logic             done_r;
  logic             busy_nxt_s;
  logic             done_nxt_s;
  logic [SLICES*WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  logic accept_s;
  logic finish_s;

  // A request is honoured only when no add is in flight (IDLE or DONE).
  assign accept_s = bus.start && ((state_r == S_IDLE) || (state_r == S_DONE));
  assign finish_s = (state_r == S_RUN) && (idx_r == LAST_IDX);

  adder_slice #(.WIDTH(WIDTH)) u_slice (
    .a    (a_r[idx_r]),
    .b    (b_r[idx_r]),
    .cin  (carry_r),
    .s    (sl_sum_s),
    .cout (sl_cout_s)
  );

  // Full result as it will look once the current slice is written back.
  always_comb begin
    final_sum_s        = shadow_r;
    final_sum_s[idx_r] = sl_sum_s;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (idx_r == LAST_IDX) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // FSM output decode, taken from the next state so the flops line up with it.
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_nxt_s)
      S_IDLE: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
      S_RUN: begin
        busy_nxt_s = 1'b1;
        done_nxt_s = 1'b0;
      end
      S_DONE: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b1;
      end
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Operand capture, slice index, inter-slice carry and partial-sum shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= '0;
      b_r      <= '0;
      shadow_r <= '0;
      idx_r    <= '0;
      carry_r  <= 1'b0;
    end else if (accept_s) begin
      a_r     <= bus.a;
      b_r     <= bus.b;
      carry_r <= bus.cin;
      idx_r   <= '0;
    end else if (state_r == S_RUN) begin
      shadow_r[idx_r] <= sl_sum_s;
      carry_r         <= sl_cout_s;
      if (idx_r != LAST_IDX) begin
        idx_r <= idx_r + IDX_W'(1);
      end else begin
        idx_r <= idx_r;
      end
    end else begin
      idx_r <= idx_r;
    end
  end

  // Registered handshake and result; results move only on the final slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
      if (finish_s) begin
        sum_r  <= final_sum_s;
        cout_r <= sl_cout_s;
        // Signed overflow: like-signed operands giving an opposite-signed sum.
        ovf_r  <= (a_r[SLICES-1][WIDTH-1] == b_r[SLICES-1][WIDTH-1]) &&
                  (final_sum_s[SLICES-1][WIDTH-1] != a_r[SLICES-1][WIDTH-1]);
      end else begin
        sum_r  <= sum_r;
        cout_r <= cout_r;
        ovf_r  <= ovf_r;
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_adder_seq_ctrl
//   Directed bench for adder_seq_ctrl with WIDTH=8, SLICES=4. Inputs are
//   driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_adder_seq_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   n;
  int   bc;

  adder_seq_ctrl_if #(.WIDTH(8), .SLICES(4)) bus ();

  adder_seq_ctrl #(.WIDTH(8), .SLICES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a request for one accepting edge; returns at the falling edge
  // right after that edge (first RUN cycle).
  task automatic launch(input logic [31:0] av, input logic [31:0] bv, input logic ci);
    bus.a     = av;
    bus.b     = bv;
    bus.cin   = ci;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Wait (bounded) for done; n counts falling edges since the accepting edge.
  task automatic wait_done(input int n0, output int nn, output int busy_cnt);
    nn       = n0;
    busy_cnt = 0;
    while (!bus.done && nn < 20) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      nn++;
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;

    // 1: reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      bus.a     = $urandom;
      bus.b     = $urandom;
      bus.cin   = 1'($urandom_range(0, 1));
      bus.start = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_sum",  64'(bus.sum),  64'd0);
      check("rst_cout", 64'(bus.cout), 64'd0);
      check("rst_ovf",  64'(bus.ovf),  64'd0);
    end
    bus.start = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);

    // 2: 0xFF + 1
    launch(32'h000000FF, 32'h00000001, 1'b0);
    check("t2_sum_held", 64'(bus.sum), 64'd0);
    wait_done(1, n, bc);
    check("t2_latency", 64'(n), 64'd5);
    check("t2_busy_cycles", 64'(bc), 64'd4);
    check("t2_busy_at_done", 64'(bus.busy), 64'd0);
    check("t2_sum",  64'(bus.sum),  64'h00000100);
    check("t2_cout", 64'(bus.cout), 64'd0);
    check("t2_ovf",  64'(bus.ovf),  64'd0);
    @(negedge clk);
    check("t2_done_pulse", 64'(bus.done), 64'd0);
    check("t2_sum_stable", 64'(bus.sum), 64'h00000100);

    // 3: carry ripples through every slice
    launch(32'hFFFFFFFF, 32'h00000000, 1'b1);
    wait_done(1, n, bc);
    check("t3_latency", 64'(n), 64'd5);
    check("t3_sum",  64'(bus.sum),  64'h00000000);
    check("t3_cout", 64'(bus.cout), 64'd1);
    check("t3_ovf",  64'(bus.ovf),  64'd0);
    @(negedge clk);

    // 4: signed overflow, positive then negative
    launch(32'h7FFFFFFF, 32'h00000001, 1'b0);
    wait_done(1, n, bc);
    check("t4a_sum",  64'(bus.sum),  64'h80000000);
    check("t4a_cout", 64'(bus.cout), 64'd0);
    check("t4a_ovf",  64'(bus.ovf),  64'd1);
    @(negedge clk);
    launch(32'h80000000, 32'h80000000, 1'b0);
    wait_done(1, n, bc);
    check("t4b_sum",  64'(bus.sum),  64'h00000000);
    check("t4b_cout", 64'(bus.cout), 64'd1);
    check("t4b_ovf",  64'(bus.ovf),  64'd1);
    @(negedge clk);

    // 5: start while busy is ignored; start in the done cycle is accepted
    launch(32'h11111111, 32'h22222222, 1'b0);
    @(negedge clk);
    bus.a     = 32'hDEADBEEF;
    bus.b     = 32'h01020304;
    bus.cin   = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(3, n, bc);
    check("t5_ignore_latency", 64'(n), 64'd5);
    check("t5_ignore_sum", 64'(bus.sum), 64'h33333333);
    check("t5_ignore_cout", 64'(bus.cout), 64'd0);
    launch(32'h00000001, 32'h00000002, 1'b0);
    check("t5_b2b_busy", 64'(bus.busy), 64'd1);
    check("t5_b2b_sum_held", 64'(bus.sum), 64'h33333333);
    wait_done(1, n, bc);
    check("t5_b2b_latency", 64'(n), 64'd5);
    check("t5_b2b_sum", 64'(bus.sum), 64'h00000003);
    @(negedge clk);
    check("t5_idle_done", 64'(bus.done), 64'd0);

    // 6: reset mid-RUN aborts with no done pulse
    launch(32'd5, 32'd6, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_abort_busy", 64'(bus.busy), 64'd0);
    check("t6_abort_sum",  64'(bus.sum),  64'd0);
    check("t6_abort_done", 64'(bus.done), 64'd0);
    bc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      if (bus.done || bus.busy) bc++;
    end
    check("t6_no_done_after_abort", 64'(bc), 64'd0);
    check("t6_idle_sum", 64'(bus.sum), 64'd0);
    launch(32'd5, 32'd6, 1'b0);
    wait_done(1, n, bc);
    check("t6_fresh_latency", 64'(n), 64'd5);
    check("t6_fresh_sum", 64'(bus.sum), 64'd11);
    check("t6_fresh_cout", 64'(bus.cout), 64'd0);
    check("t6_fresh_ovf", 64'(bus.ovf), 64'd0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
